event_id_trig_sched: RTL and testbench

Trigger scheduler and sequencer for the tracker event-ID generator.
- Arbitrates trigger requests from N_SRC sources using round-robin.
- On each grant, assigns the next event ID and serializes it to the front-end boards on a single line.
- Enforces a dead time before the next grant.
- Sits between the trigger sources and the AXI-Lite event-ID register block. That block supplies enable, load and clear controls and reads back the status outputs.

---
 rtl/event_id_trig_sched.sv | 157 +++++++++++++++
 tb/tb_event_id_trig_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_id_trig_sched.sv
// Trigger scheduler for the tracker event-ID generator.
// Round-robin grant across trigger sources, event-ID assignment, serial ID
// broadcast to the front-end boards and a fixed dead time between frames.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for an enabled request; ser_out low
//   SEND   | shifting {1, id} out MSB first, CLK_DIV cycles per bit
//   DEAD   | enforced quiet time of DEAD_CYCLES before the next grant
module event_id_trig_sched #(
   parameter int N_SRC       = 4,
   parameter int ID_WIDTH    = 32,
   parameter int CLK_DIV     = 4,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                enable,
   input  logic                id_load,
   input  logic [ID_WIDTH-1:0] id_load_val,
   input  logic [N_SRC-1:0]    trig_req,
   output logic [N_SRC-1:0]    trig_ack,
   output logic [ID_WIDTH-1:0] event_id,
   output logic [2:0]          event_src,
   output logic [ID_WIDTH-1:0] next_id,
   output logic                ser_out,
   output logic                busy,
   output logic [31:0]         trig_cnt
);

   localparam int BW = $clog2(ID_WIDTH + 1);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int TW = $clog2(DEAD_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        ptr;
   logic [2:0]        grant_idx;
   logic [2:0]        hi_idx;
   logic [2:0]        lo_idx;
   logic              hi_found;
   logic              lo_found;
   logic              grant;
   logic [ID_WIDTH:0] shreg;
   logic [BW-1:0]     bit_cnt;
   logic [DW-1:0]     div_cnt;
   logic [TW-1:0]     dead_cnt;
   logic              bit_done;
   logic              frame_done;
   logic              dead_done;

   assign bit_done   = (div_cnt == '0);
   assign frame_done = bit_done && (bit_cnt == '0);
   assign dead_done  = (dead_cnt == '0);

   // Round-robin winner: lowest request at/above ptr, else lowest overall (wrap).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int j = N_SRC - 1; j >= 0; j--) begin
         if (trig_req[j]) begin
            lo_found = 1'b1;
            lo_idx   = 3'(j);
            if (3'(j) >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = 3'(j);
            end
         end
      end
      grant_idx = hi_found ? hi_idx : lo_idx;
      grant     = (state == S_IDLE) && enable && lo_found;
   end

   // State register.
   always_ff @(posedge ACLK) begin
      if (ARESET) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (grant)      state_nxt = S_SEND;
         S_SEND: if (frame_done) state_nxt = S_DEAD;
         S_DEAD: if (dead_done)  state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; the serial line is the shifter MSB while sending.
   always_comb begin
      busy    = (state != S_IDLE);
      ser_out = (state == S_SEND) && shreg[ID_WIDTH];
   end

   // Grant bookkeeping, ID counter, frame shifter and down-counter timers.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         trig_ack  <= '0;
         event_id  <= '0;
         event_src <= '0;
         next_id   <= '0;
         trig_cnt  <= '0;
         ptr       <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         dead_cnt  <= '0;
      end else begin
         trig_ack <= '0;

         // Load wins over increment; the grant still issues the old value.
         if (id_load)    next_id <= id_load_val;
         else if (grant) next_id <= next_id + ID_WIDTH'(1);

         case (state)
            S_IDLE: begin
               if (grant) begin
                  trig_ack  <= N_SRC'(1) << grant_idx;
                  event_id  <= next_id;
                  event_src <= grant_idx;
                  trig_cnt  <= trig_cnt + 32'd1;
                  ptr       <= (grant_idx == 3'(N_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;
                  shreg     <= {1'b1, next_id};
                  bit_cnt   <= BW'(ID_WIDTH);
                  div_cnt   <= DW'(CLK_DIV - 1);
               end
            end
            S_SEND: begin
               if (!bit_done) begin
                  div_cnt <= div_cnt - DW'(1);
               end else if (!frame_done) begin
                  shreg   <= {shreg[ID_WIDTH-1:0], 1'b0};
                  bit_cnt <= bit_cnt - BW'(1);
                  div_cnt <= DW'(CLK_DIV - 1);
               end else begin
                  dead_cnt <= TW'(DEAD_CYCLES - 1);
               end
            end
            S_DEAD: begin
               if (!dead_done) dead_cnt <= dead_cnt - TW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_event_id_trig_sched.sv
// Bench for event_id_trig_sched: directed scenarios plus randomized grants,
// checked against a request-list / ID-counter reference model.
module tb_event_id_trig_sched;

   localparam int N_SRC = 4;
   localparam int IDW   = 8;
   localparam int CDIV  = 2;
   localparam int DEADC = 4;
   localparam int FRAME_CYC = (IDW + 1) * CDIV;
   localparam int BUSY_CYC  = FRAME_CYC + DEADC;

   logic             ACLK = 1'b0;
   logic             ARESET;
   logic             enable;
   logic             id_load;
   logic [IDW-1:0]   id_load_val;
   logic [N_SRC-1:0] trig_req;
   logic [N_SRC-1:0] trig_ack;
   logic [IDW-1:0]   event_id;
   logic [2:0]       event_src;
   logic [IDW-1:0]   next_id;
   logic             ser_out;
   logic             busy;
   logic [31:0]      trig_cnt;

   event_id_trig_sched #(
      .N_SRC(N_SRC), .ID_WIDTH(IDW), .CLK_DIV(CDIV), .DEAD_CYCLES(DEADC)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .id_load(id_load),
      .id_load_val(id_load_val), .trig_req(trig_req), .trig_ack(trig_ack),
      .event_id(event_id), .event_src(event_src), .next_id(next_id),
      .ser_out(ser_out), .busy(busy), .trig_cnt(trig_cnt)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   // Reference model state
   logic [IDW-1:0] m_next;
   logic [31:0]    m_cnt;
   int             m_ptr;
   int             last_ack_cyc = 0;
   int             last_gap = 0;
   int             last_src = -1;
   logic [IDW-1:0] last_id;

   function automatic int pick(input logic [N_SRC-1:0] r, input int p);
      for (int i = 0; i < N_SRC; i++) begin
         int idx;
         idx = (p + i) % N_SRC;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_next = '0;
      m_cnt  = '0;
      m_ptr  = 0;
   endtask

   task automatic apply_reset();
      @(negedge ACLK);
      ARESET = 1'b1; trig_req = '0; id_load = 1'b0;
      @(negedge ACLK);
      ARESET = 1'b0;
      model_reset();
   endtask

   task automatic load_id(input logic [IDW-1:0] v);
      id_load = 1'b1; id_load_val = v;
      @(negedge ACLK);
      id_load = 1'b0;
      m_next = v;
   endtask

   // Caller is at the negedge just after the ack edge.
   task automatic check_frame(input logic [IDW-1:0] id, input string name);
      logic [IDW:0] f;
      logic exp_s;
      f = {1'b1, id};
      for (int k = 0; k < BUSY_CYC; k++) begin
         if (k > 0) @(negedge ACLK);
         exp_s = (k < FRAME_CYC) ? f[IDW - k / CDIV] : 1'b0;
         n_cmp++;
         if (ser_out !== exp_s) begin
            n_err++;
            $display("FAIL %s ser_out cycle %0d: got %b want %b", name, k, ser_out, exp_s);
         end
         n_cmp++;
         if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy);
         end
         if (k == 1) begin
            n_cmp++;
            if (trig_ack !== '0) begin
               n_err++;
               $display("FAIL %s ack_one_cycle: got %b want 0000", name, trig_ack);
            end
         end
      end
      @(negedge ACLK);
      n_cmp++;
      if (busy !== 1'b0 || ser_out !== 1'b0) begin
         n_err++;
         $display("FAIL %s idle_after_dead: got busy=%b ser=%b want 0 0", name, busy, ser_out);
      end
   endtask

   // Drives req (and optional load) at a negedge, waits for the grant, checks it and its frame.
   task automatic grant(input logic [N_SRC-1:0] req, input logic ld,
                        input logic [IDW-1:0] ldv, input string name);
      logic got, coinc;
      int exp_g;
      logic [IDW-1:0] exp_id;
      trig_req = req; id_load = ld; id_load_val = ldv;
      got = 1'b0; coinc = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge ACLK);
         if (t == 0 && ld) begin
            id_load = 1'b0;
            coinc = (trig_ack != '0);
            if (!coinc) m_next = ldv;
         end
         if (trig_ack != '0) begin
            got = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL %s ack_timeout: got none want ack", name);
         return;
      end
      exp_g  = pick(req, m_ptr);
      exp_id = m_next;
      m_next = coinc ? ldv : m_next + 8'd1;
      m_cnt  = m_cnt + 32'd1;
      m_ptr  = (exp_g + 1) % N_SRC;
      last_gap = cyc - last_ack_cyc;
      last_ack_cyc = cyc;
      last_src = exp_g;
      last_id  = exp_id;
      if (trig_ack !== N_SRC'(1 << exp_g)) begin
         n_err++;
         $display("FAIL %s trig_ack: got %b want %b", name, trig_ack, N_SRC'(1 << exp_g));
      end
      n_cmp++;
      if (event_id !== exp_id) begin
         n_err++;
         $display("FAIL %s event_id: got %h want %h", name, event_id, exp_id);
      end
      n_cmp++;
      if (event_src !== 3'(exp_g)) begin
         n_err++;
         $display("FAIL %s event_src: got %0d want %0d", name, event_src, exp_g);
      end
      n_cmp++;
      if (next_id !== m_next) begin
         n_err++;
         $display("FAIL %s next_id: got %h want %h", name, next_id, m_next);
      end
      n_cmp++;
      if (trig_cnt !== m_cnt) begin
         n_err++;
         $display("FAIL %s trig_cnt: got %0d want %0d", name, trig_cnt, m_cnt);
      end
      trig_req = trig_req & ~trig_ack;
      trig_req[exp_g] = 1'b0;
      check_frame(exp_id, name);
   endtask

   task automatic test_reset();
      ARESET = 1'b1; enable = 1'b0; id_load = 1'b0; id_load_val = '0; trig_req = '0;
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      model_reset();
      n_cmp++;
      if ({trig_ack, event_id, event_src, next_id, ser_out, busy, trig_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset outputs: got ack=%b id=%h src=%0d nid=%h ser=%b busy=%b cnt=%0d want all 0",
                  trig_ack, event_id, event_src, next_id, ser_out, busy, trig_cnt);
      end
   endtask

   task automatic test_single();
      enable = 1'b1;
      grant(4'b0100, 1'b0, '0, "single");
      n_cmp++;
      if (event_src !== 3'd2 || event_id !== 8'h00 || next_id !== 8'h01) begin
         n_err++;
         $display("FAIL single fixed: got src=%0d id=%h nid=%h want 2 00 01", event_src, event_id, next_id);
      end
   endtask

   task automatic test_load();
      load_id(8'hA5);
      grant(4'b0001, 1'b0, '0, "load");
      n_cmp++;
      if (event_id !== 8'hA5 || next_id !== 8'hA6) begin
         n_err++;
         $display("FAIL load fixed: got id=%h nid=%h want A5 A6", event_id, next_id);
      end
   endtask

   task automatic test_back_to_back();
      int order[4];
      apply_reset();
      enable = 1'b1;
      trig_req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         grant(trig_req, 1'b0, '0, "b2b");
         order[i] = last_src;
         if (i > 0) begin
            n_cmp++;
            if (last_gap != BUSY_CYC + 1) begin
               n_err++;
               $display("FAIL b2b gap %0d: got %0d want %0d", i, last_gap, BUSY_CYC + 1);
            end
         end
         n_cmp++;
         if (event_src !== 3'(i) || event_id !== 8'(i)) begin
            n_err++;
            $display("FAIL b2b order %0d: got src=%0d id=%h want %0d %h", i, event_src, event_id, i, 8'(i));
         end
      end
      n_cmp++;
      if (trig_cnt !== 32'd4) begin
         n_err++;
         $display("FAIL b2b trig_cnt: got %0d want 4", trig_cnt);
      end
   endtask

   task automatic test_wrap();
      load_id(8'hFF);
      grant(4'b0010, 1'b0, '0, "wrap1");
      n_cmp++;
      if (event_id !== 8'hFF) begin
         n_err++;
         $display("FAIL wrap first: got %h want FF", event_id);
      end
      grant(4'b1000, 1'b0, '0, "wrap2");
      n_cmp++;
      if (event_id !== 8'h00 || next_id !== 8'h01) begin
         n_err++;
         $display("FAIL wrap second: got id=%h nid=%h want 00 01", event_id, next_id);
      end
   endtask

   task automatic test_load_coincident();
      load_id(8'h10);
      grant(4'b0100, 1'b1, 8'h40, "coinc");
      n_cmp++;
      if (last_id !== 8'h10 || event_id !== 8'h10 || next_id !== 8'h40) begin
         n_err++;
         $display("FAIL coinc fixed: got id=%h nid=%h want 10 40", event_id, next_id);
      end
   endtask

   task automatic test_enable();
      logic seen;
      enable = 1'b0;
      trig_req = 4'b0001;
      seen = 1'b0;
      repeat (30) begin
         @(negedge ACLK);
         if (trig_ack != '0) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_err++;
         $display("FAIL enable_off: got ack want none");
      end
      enable = 1'b1;
      grant(trig_req, 1'b0, '0, "enable_on");
   endtask

   task automatic test_reset_mid_frame();
      logic got;
      got = 1'b0;
      trig_req = 4'b0001;
      for (int t = 0; t < 100; t++) begin
         @(negedge ACLK);
         if (trig_ack != '0) begin got = 1'b1; break; end
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL midrst ack_timeout: got none want ack");
      end
      trig_req = 4'b0010;
      repeat (5) @(negedge ACLK);
      ARESET = 1'b1;
      @(negedge ACLK);
      n_cmp++;
      if (ser_out !== 1'b0 || busy !== 1'b0 || next_id !== '0 || trig_cnt !== '0
          || event_id !== '0 || trig_ack !== '0) begin
         n_err++;
         $display("FAIL midrst outputs: got ser=%b busy=%b nid=%h cnt=%0d want 0 0 00 0",
                  ser_out, busy, next_id, trig_cnt);
      end
      ARESET = 1'b0;
      model_reset();
      grant(4'b0010, 1'b0, '0, "midrst_regrant");
      n_cmp++;
      if (event_src !== 3'd1 || event_id !== 8'h00) begin
         n_err++;
         $display("FAIL midrst regrant: got src=%0d id=%h want 1 00", event_src, event_id);
      end
   endtask

   task automatic test_random();
      apply_reset();
      enable = 1'b1;
      for (int r = 0; r < 12; r++) begin
         logic [N_SRC-1:0] req;
         logic ld;
         req = trig_req | N_SRC'($urandom_range(1, 15));
         ld  = ($urandom_range(0, 3) == 0);
         grant(req, ld, IDW'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_load();
      test_back_to_back();
      test_wrap();
      test_load_coincident();
      test_enable();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
